run_monitor: RTL and testbench

Synthesisable run-control and post-mortem monitor for the pipelined RV32 core, and the successor to the simulation-only halt detection in the pipeline testbench. It counts cycles and decoded instructions, stops on ECALL, EBREAK or a parametrised timeout, and captures the halting PC aligned to the decode pulse. An optional ring buffer keeps the last N ID-stage PCs. It sits beside `top`, fed from the ID stage and the core's `ecall_pulse`/`ebreak_pulse` outputs.

---
 rtl/run_monitor_if.sv | 36 +++
 rtl/run_monitor.sv | 166 ++++++++++++++++
 tb/tb_run_monitor.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_monitor_if.sv
// Signal bundle between the RV32 core's ID stage / run control and run_monitor.
// The master side drives run control, ID-stage taps and trace read index; the slave is the monitor.
interface run_monitor_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 64,
    parameter int IDX_W = 4
);
    logic             start;
    logic             clear;
    logic [PC_W-1:0]  id_pc;
    logic             id_valid;
    logic             ecall_pulse;
    logic             ebreak_pulse;
    logic [1:0]       state;
    logic             done;
    logic [1:0]       halt_cause;
    logic [PC_W-1:0]  halt_pc;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;
    logic [IDX_W-1:0] trace_rd_idx;
    logic [PC_W-1:0]  trace_rd_data;
    logic             trace_rd_valid;
    logic [IDX_W:0]   trace_count;

    modport master (
        output start, clear, id_pc, id_valid, ecall_pulse, ebreak_pulse, trace_rd_idx,
        input  state, done, halt_cause, halt_pc, cycle_count, instr_count,
               trace_rd_data, trace_rd_valid, trace_count
    );

    modport slave (
        input  start, clear, id_pc, id_valid, ecall_pulse, ebreak_pulse, trace_rd_idx,
        output state, done, halt_cause, halt_pc, cycle_count, instr_count,
               trace_rd_data, trace_rd_valid, trace_count
    );
endinterface

// File: rtl/run_monitor.sv
// Run-control / post-mortem monitor: cycle and instruction counters, ECALL/EBREAK/timeout stop,
// halting-PC capture. Optional PC trace ring built when RUN_MONITOR_TRACE_EN is defined.
module run_monitor #(
    parameter int              PC_W        = 32,
    parameter int              CNT_W       = 64,
    parameter longint unsigned TIMEOUT     = 64'd50_000_000,
    parameter int              TRACE_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    run_monitor_if.slave mon
);
    localparam int               IDX_W    = $clog2(TRACE_DEPTH);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        TMO  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       halt_cause_q, halt_cause_d;
    logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             run_en;
    logic             run_start;

    always_comb begin
        state_d       = state_q;
        halt_cause_d  = halt_cause_q;
        halt_pc_d     = halt_pc_q;
        pc_d          = pc_q;
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        run_en        = 1'b0;
        run_start     = 1'b0;
        // clear pre-empts everything else, including the RUN bookkeeping of this cycle
        if (mon.clear) begin
            state_d      = IDLE;
            halt_cause_d = 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mon.start) begin
                        state_d       = RUN;
                        run_start     = 1'b1;
                        cycle_count_d = '0;
                        instr_count_d = '0;
                        halt_cause_d  = 2'b00;
                    end
                end
                RUN: begin
                    run_en        = 1'b1;
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                    pc_d          = mon.id_pc;
                    if (mon.id_valid && (instr_count_q != '1)) begin
                        instr_count_d = instr_count_q + CNT_W'(1);
                    end
                    // pulses trail the instruction by one cycle, so the halting PC is pc_q
                    if (mon.ecall_pulse || mon.ebreak_pulse) begin
                        state_d      = HALT;
                        halt_pc_d    = pc_q;
                        halt_cause_d = mon.ecall_pulse ? 2'b01 : 2'b10;
                    end else if (cycle_count_q == TMO_LAST) begin
                        state_d      = TMO;
                        halt_pc_d    = pc_q;
                        halt_cause_d = 2'b11;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            halt_cause_q  <= 2'b00;
            halt_pc_q     <= '0;
            pc_q          <= '0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            halt_cause_q  <= halt_cause_d;
            halt_pc_q     <= halt_pc_d;
            pc_q          <= pc_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign mon.state       = state_q;
    assign mon.done        = state_q[1];
    assign mon.halt_cause  = halt_cause_q;
    assign mon.halt_pc     = halt_pc_q;
    assign mon.cycle_count = cycle_count_q;
    assign mon.instr_count = instr_count_q;

`ifdef RUN_MONITOR_TRACE_EN
    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(TRACE_DEPTH);

    logic [PC_W-1:0]  trace_mem [TRACE_DEPTH];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]   trace_count_q, trace_count_d;
    logic [PC_W-1:0]  trace_rd_data_q, trace_rd_data_d;
    logic             trace_rd_valid_q, trace_rd_valid_d;
    logic             trace_we;
    logic [IDX_W-1:0] rd_addr;

    always_comb begin
        trace_we      = run_en && mon.id_valid;
        wr_ptr_d      = wr_ptr_q;
        trace_count_d = trace_count_q;
        if (run_start) begin
            wr_ptr_d      = '0;
            trace_count_d = '0;
        end else if (trace_we) begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            if (trace_count_q != DEPTH_CNT) begin
                trace_count_d = trace_count_q + (IDX_W+1)'(1);
            end
        end
        // index 0 is the newest entry; reads see the RAM before this cycle's write
        rd_addr          = wr_ptr_q - IDX_W'(1) - mon.trace_rd_idx;
        trace_rd_valid_d = ({1'b0, mon.trace_rd_idx} < trace_count_q);
        trace_rd_data_d  = trace_rd_valid_d ? trace_mem[rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (trace_we) begin
            trace_mem[wr_ptr_q] <= mon.id_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q         <= '0;
            trace_count_q    <= '0;
            trace_rd_data_q  <= '0;
            trace_rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            trace_count_q    <= trace_count_d;
            trace_rd_data_q  <= trace_rd_data_d;
            trace_rd_valid_q <= trace_rd_valid_d;
        end
    end

    assign mon.trace_rd_data  = trace_rd_data_q;
    assign mon.trace_rd_valid = trace_rd_valid_q;
    assign mon.trace_count    = trace_count_q;
`else
    logic unused_trace;
    assign unused_trace = ^{mon.trace_rd_idx, run_en, run_start};

    assign mon.trace_rd_data  = '0;
    assign mon.trace_rd_valid = 1'b0;
    assign mon.trace_count    = '0;
`endif
endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: expectations are queued when stimulus is applied and
// popped against DUT outputs once they are due. Runs with trace either enabled or disabled.
module tb_run_monitor;
    localparam int              PC_W  = 32;
    localparam int              CNT_W = 64;
    localparam int              DEPTH = 4;
    localparam int              IDX_W = 2;
    localparam longint unsigned TMO_N = 64'd12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    run_monitor_if #(.PC_W(PC_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

    run_monitor #(
        .PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT(TMO_N), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mon(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_pop(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [63:0] tc(input int n);
`ifdef RUN_MONITOR_TRACE_EN
        return 64'(n);
`else
        return 64'(n) & 64'd0;
`endif
    endfunction

    task automatic trace_read(input logic [IDX_W-1:0] idx, input logic v, input logic [PC_W-1:0] d);
        logic ev;
        logic [PC_W-1:0] ed;
        ev = v;
        ed = d;
`ifndef RUN_MONITOR_TRACE_EN
        ev = 1'b0;
        ed = '0;
`endif
        bus.trace_rd_idx = idx;
        expect_v($sformatf("trace_valid[%0d]", idx), 64'(ev));
        expect_v($sformatf("trace_data[%0d]", idx), 64'(ed));
        tick();
        check_pop(64'(bus.trace_rd_valid));
        check_pop(64'(bus.trace_rd_data));
    endtask

    task automatic expect_status(input string tag, input logic [1:0] st, input logic [1:0] cause,
                                 input logic [63:0] cyc, input logic [63:0] ins);
        expect_v({tag, "_state"}, 64'(st));
        expect_v({tag, "_done"}, 64'(st[1]));
        expect_v({tag, "_cause"}, 64'(cause));
        expect_v({tag, "_cycles"}, cyc);
        expect_v({tag, "_instrs"}, ins);
    endtask

    task automatic pop_status();
        check_pop(64'(bus.state));
        check_pop(64'(bus.done));
        check_pop(64'(bus.halt_cause));
        check_pop(bus.cycle_count);
        check_pop(bus.instr_count);
    endtask

    task automatic idle_inputs();
        bus.start        = 1'b0;
        bus.clear        = 1'b0;
        bus.id_pc        = '0;
        bus.id_valid     = 1'b0;
        bus.ecall_pulse  = 1'b0;
        bus.ebreak_pulse = 1'b0;
        bus.trace_rd_idx = '0;
    endtask

    task automatic reset_expect(input string tag);
        expect_status(tag, 2'd0, 2'd0, 64'd0, 64'd0);
        expect_v({tag, "_halt_pc"}, 64'd0);
        expect_v({tag, "_trace_count"}, 64'd0);
        expect_v({tag, "_trace_valid"}, 64'd0);
        expect_v({tag, "_trace_data"}, 64'd0);
    endtask

    task automatic reset_pop();
        pop_status();
        check_pop(64'(bus.halt_pc));
        check_pop(64'(bus.trace_count));
        check_pop(64'(bus.trace_rd_valid));
        check_pop(64'(bus.trace_rd_data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int n;
        idle_inputs();

        // ---- reset state
        rst_n = 1'b0;
        reset_expect("reset");
        tick();
        tick();
        reset_pop();
        rst_n = 1'b1;

        // ---- basic ECALL halt: PCs 0x0..0x20 then ECALL
        bus.start = 1'b1;
        expect_v("start_state", 64'd1);
        tick();
        check_pop(64'(bus.state));
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.id_pc    = 32'(4 * i);
            bus.id_valid = 1'b1;
            tick();
        end
        bus.id_valid    = 1'b0;
        bus.id_pc       = 32'hdead_0000;
        bus.ecall_pulse = 1'b1;
        expect_v("ecall_done_before_edge", 64'd0);
        check_pop(64'(bus.done));
        expect_status("ecall", 2'd2, 2'b01, 64'd10, 64'd9);
        expect_v("ecall_halt_pc", 64'h20);
        expect_v("ecall_trace_count", tc(4));
        tick();
        bus.ecall_pulse = 1'b0;
        pop_status();
        check_pop(64'(bus.halt_pc));
        check_pop(64'(bus.trace_count));
        trace_read(2'd0, 1'b1, 32'h20);
        trace_read(2'd3, 1'b1, 32'h14);

        // ---- HALT is sticky against pulses, start and id_valid
        bus.ebreak_pulse = 1'b1;
        bus.start        = 1'b1;
        bus.id_valid     = 1'b1;
        expect_status("sticky", 2'd2, 2'b01, 64'd10, 64'd9);
        tick();
        tick();
        pop_status();
        idle_inputs();

        // ---- clear and start together in HALT: IDLE, counters retained
        bus.clear = 1'b1;
        bus.start = 1'b1;
        expect_status("clear_prio", 2'd0, 2'b00, 64'd10, 64'd9);
        tick();
        pop_status();
        bus.clear = 1'b0;

        // ---- simultaneous pulses: ECALL wins; later EBREAK ignored
        expect_status("restart", 2'd1, 2'b00, 64'd0, 64'd0);
        tick();
        pop_status();
        bus.start = 1'b0;
        bus.id_valid = 1'b1;
        bus.id_pc    = 32'h40;
        tick();
        bus.id_pc    = 32'h44;
        tick();
        bus.id_valid     = 1'b0;
        bus.id_pc        = 32'h99;
        bus.ecall_pulse  = 1'b1;
        bus.ebreak_pulse = 1'b1;
        expect_status("both", 2'd2, 2'b01, 64'd3, 64'd2);
        expect_v("both_halt_pc", 64'h44);
        tick();
        pop_status();
        check_pop(64'(bus.halt_pc));
        bus.ecall_pulse = 1'b0;
        expect_v("late_ebreak_cause", 64'b01);
        tick();
        check_pop(64'(bus.halt_cause));
        bus.ebreak_pulse = 1'b0;
        expect_v("two_trace_count", tc(2));
        check_pop(64'(bus.trace_count));
        trace_read(2'd2, 1'b0, 32'h0);
        trace_read(2'd1, 1'b1, 32'h40);
        trace_read(2'd0, 1'b1, 32'h44);

        // ---- timeout after exactly TIMEOUT RUN cycles
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.id_pc = 32'h300;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n++;
            if (bus.done) break;
        end
        expect_v("tmo_run_cycles", 64'd12);
        check_pop(64'(n));
        expect_status("tmo", 2'd3, 2'b11, 64'd12, 64'd0);
        expect_v("tmo_halt_pc", 64'h300);
        pop_status();
        check_pop(64'(bus.halt_pc));

        // ---- pulse on the last pre-timeout cycle wins over timeout
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        bus.ebreak_pulse = 1'b1;
        expect_status("pulse_vs_tmo", 2'd2, 2'b10, 64'd12, 64'd0);
        tick();
        pop_status();
        bus.ebreak_pulse = 1'b0;

        // ---- trace wrap with 6 PCs, then reset mid-RUN
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.id_pc    = 32'h100 + 32'(4 * i);
            bus.id_valid = 1'b1;
            if (i == 5) trace_read(2'd0, 1'b1, 32'h110);
            else tick();
        end
        bus.id_valid = 1'b0;
        expect_v("wrap_trace_count", tc(4));
        expect_v("wrap_instrs", 64'd6);
        check_pop(64'(bus.trace_count));
        check_pop(bus.instr_count);
        trace_read(2'd0, 1'b1, 32'h114);
        trace_read(2'd1, 1'b1, 32'h110);
        trace_read(2'd3, 1'b1, 32'h108);
        expect_v("wrap_still_run", 64'd1);
        check_pop(64'(bus.state));
        rst_n = 1'b0;
        reset_expect("midrun_reset");
        tick();
        reset_pop();
        rst_n = 1'b1;

        // ---- bubbles on alternate cycles
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.id_valid = (i % 2 == 0);
            bus.id_pc    = 32'h200 + 32'(4 * i);
            tick();
        end
        bus.id_valid = 1'b0;
        expect_status("bubbles", 2'd1, 2'b00, 64'd10, 64'd5);
        expect_v("bubbles_trace_count", tc(4));
        pop_status();
        check_pop(64'(bus.trace_count));
        trace_read(2'd0, 1'b1, 32'h220);
        trace_read(2'd3, 1'b1, 32'h208);

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
